// File: rtl/br_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : br_write_arbiter_if
//  Purpose  : Bundle of request, bank-write and read-bypass signals shared
//             between the writeback requesters and the register-bank arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface br_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              hold;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              lnk_valid;
  logic [DATA_W-1:0] lnk_data;
  logic              lnk_ready;
  logic              br_we;
  logic [ADDR_W-1:0] br_waddr;
  logic [DATA_W-1:0] br_wdata;
  logic              br_jal;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              byp_a_hit;
  logic              byp_b_hit;
  logic [DATA_W-1:0] byp_data;

  // Arbiter side
  modport slave (
    input  hold,
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    input  lnk_valid, lnk_data,
    output lnk_ready,
    output br_we, br_waddr, br_wdata, br_jal,
    input  rd_addr_a, rd_addr_b,
    output byp_a_hit, byp_b_hit, byp_data
  );

  // Requester / bank side
  modport master (
    output hold,
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    output lnk_valid, lnk_data,
    input  lnk_ready,
    input  br_we, br_waddr, br_wdata, br_jal,
    output rd_addr_a, rd_addr_b,
    input  byp_a_hit, byp_b_hit, byp_data
  );
endinterface
`default_nettype wire

// File: rtl/br_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : br_write_arbiter
//  Purpose  : Round-robin arbiter sharing the register bank's single write
//             port between ALU, load and link writebacks, with a one-entry
//             staging slot and a read-bypass view of the staged write.
//  Revision : 1.0  initial release
// ============================================================================
module br_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  br_write_arbiter_if.slave bus
);

  localparam logic [1:0]        REQ_ALU   = 2'd0;
  localparam logic [1:0]        REQ_MEM   = 2'd1;
  localparam logic [1:0]        REQ_LNK   = 2'd2;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  logic [1:0]        rr_ptr_q,   rr_ptr_d;
  logic              br_we_q,    br_we_d;
  logic              br_jal_q,   br_jal_d;
  logic [ADDR_W-1:0] br_waddr_q, br_waddr_d;
  logic [DATA_W-1:0] br_wdata_q, br_wdata_d;

  logic [2:0]        req_vec;
  logic              grant_any;
  logic [1:0]        grant_idx;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign req_vec   = {bus.lnk_valid, bus.mem_valid, bus.alu_valid};
  assign grant_any = |req_vec;

  // Round-robin search: first valid requester starting from rr_ptr
  always_comb begin
    grant_idx = REQ_ALU;
    case (rr_ptr_q)
      REQ_MEM: begin
        if      (req_vec[REQ_MEM]) grant_idx = REQ_MEM;
        else if (req_vec[REQ_LNK]) grant_idx = REQ_LNK;
        else                       grant_idx = REQ_ALU;
      end
      REQ_LNK: begin
        if      (req_vec[REQ_LNK]) grant_idx = REQ_LNK;
        else if (req_vec[REQ_ALU]) grant_idx = REQ_ALU;
        else                       grant_idx = REQ_MEM;
      end
      default: begin
        if      (req_vec[REQ_ALU]) grant_idx = REQ_ALU;
        else if (req_vec[REQ_MEM]) grant_idx = REQ_MEM;
        else                       grant_idx = REQ_LNK;
      end
    endcase
  end

  // The staging slot is rewritten every cycle, so acceptance only waits on
  // hold; reset also gates it so no request is consumed while in reset.
  assign accept        = grant_any & ~bus.hold & rst_n;
  assign bus.alu_ready = accept & (grant_idx == REQ_ALU);
  assign bus.mem_ready = accept & (grant_idx == REQ_MEM);
  assign bus.lnk_ready = accept & (grant_idx == REQ_LNK);

  // Select address/data of the granted requester; link writes target LINK_REG
  always_comb begin
    sel_addr = bus.alu_addr;
    sel_data = bus.alu_data;
    case (grant_idx)
      REQ_MEM: begin
        sel_addr = bus.mem_addr;
        sel_data = bus.mem_data;
      end
      REQ_LNK: begin
        sel_addr = LINK_ADDR;
        sel_data = bus.lnk_data;
      end
      default: begin
        sel_addr = bus.alu_addr;
        sel_data = bus.alu_data;
      end
    endcase
  end

  // Next pointer and staging slot; writes to $0 are consumed but dropped
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    br_we_d    = 1'b0;
    br_jal_d   = 1'b0;
    br_waddr_d = br_waddr_q;
    br_wdata_d = br_wdata_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == REQ_LNK) ? REQ_ALU : grant_idx + 2'd1;
      if (sel_addr != ZERO_ADDR) begin
        br_we_d    = 1'b1;
        br_jal_d   = (grant_idx == REQ_LNK);
        br_waddr_d = sel_addr;
        br_wdata_d = sel_data;
      end
    end
  end

  // State registers; reset discards any staged write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= REQ_ALU;
      br_we_q    <= 1'b0;
      br_jal_q   <= 1'b0;
      br_waddr_q <= '0;
      br_wdata_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      br_we_q    <= br_we_d;
      br_jal_q   <= br_jal_d;
      br_waddr_q <= br_waddr_d;
      br_wdata_q <= br_wdata_d;
    end
  end

  assign bus.br_we    = br_we_q;
  assign bus.br_jal   = br_jal_q;
  assign bus.br_waddr = br_waddr_q;
  assign bus.br_wdata = br_wdata_q;

  // Bypass covers the cycle before the bank commits the staged write
  assign bus.byp_a_hit = br_we_q & (br_waddr_q == bus.rd_addr_a) & (bus.rd_addr_a != ZERO_ADDR);
  assign bus.byp_b_hit = br_we_q & (br_waddr_q == bus.rd_addr_b) & (bus.rd_addr_b != ZERO_ADDR);
  assign bus.byp_data  = br_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_br_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_br_write_arbiter
//  Purpose  : Scoreboard bench for br_write_arbiter with a behavioural bank.
//  Revision : 1.0  initial release
// ============================================================================
module tb_br_write_arbiter;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        j;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  int   exp_grant[$];
  wr_t  exp_wr[$];
  logic [31:0] bank [32];

  br_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  br_write_arbiter #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural register bank fed by the write port; $0 stays zero
  always @(posedge clk) begin
    if (rst_n && bus.br_we && bus.br_waddr != 5'd0)
      bank[bus.br_waddr] <= bus.br_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic wr_t mk(input logic [4:0] a, input logic [31:0] d, input logic j);
    wr_t w;
    w.a = a; w.d = d; w.j = j;
    return w;
  endfunction

  // Monitor: compare grants and staged writes against the scoreboard queues
  always @(negedge clk) begin
    logic [2:0] r;
    int g;
    wr_t w;
    if (rst_n) begin
      r = {bus.lnk_ready, bus.mem_ready, bus.alu_ready};
      if (r != 3'b000) begin
        chk("ready_onehot", 64'($countones(r)), 64'd1);
        if (exp_grant.size() == 0) chk("grant_unexpected", 64'(r), 64'd0);
        else begin
          g = exp_grant.pop_front();
          chk("grant_src", 64'(r), 64'(3'b001 << g));
        end
      end
      if (bus.br_we) begin
        if (exp_wr.size() == 0) chk("write_unexpected", 64'd1, 64'd0);
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 64'(bus.br_waddr), 64'(w.a));
          chk("wr_data", 64'(bus.br_wdata), 64'(w.d));
          chk("wr_jal",  64'(bus.br_jal),   64'(w.j));
        end
      end
    end
  end

  // Requester protocol: a pending request must stay stable until ready
  logic        pv_a = 0, pr_a = 0, pv_m = 0, pr_m = 0, pv_l = 0, pr_l = 0;
  logic [4:0]  pa_a = 0, pa_m = 0;
  logic [31:0] pd_a = 0, pd_m = 0, pd_l = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (pv_a && !pr_a)
        assert (bus.alu_valid && bus.alu_addr == pa_a && bus.alu_data == pd_a)
          else $error("alu requester changed before ready");
      if (pv_m && !pr_m)
        assert (bus.mem_valid && bus.mem_addr == pa_m && bus.mem_data == pd_m)
          else $error("mem requester changed before ready");
      if (pv_l && !pr_l)
        assert (bus.lnk_valid && bus.lnk_data == pd_l)
          else $error("lnk requester changed before ready");
    end
    pv_a <= bus.alu_valid; pr_a <= bus.alu_ready; pa_a <= bus.alu_addr; pd_a <= bus.alu_data;
    pv_m <= bus.mem_valid; pr_m <= bus.mem_ready; pa_m <= bus.mem_addr; pd_m <= bus.mem_data;
    pv_l <= bus.lnk_valid; pr_l <= bus.lnk_ready; pd_l <= bus.lnk_data;
  end

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'd0;
    bus.hold = 0;
    bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_data = 0;
    bus.lnk_valid = 0; bus.lnk_data = 0;
    bus.rd_addr_a = 0; bus.rd_addr_b = 0;

    // Reset state
    #2;
    chk("rst_br_we",    64'(bus.br_we),    64'd0);
    chk("rst_br_jal",   64'(bus.br_jal),   64'd0);
    chk("rst_br_waddr", 64'(bus.br_waddr), 64'd0);
    chk("rst_br_wdata", 64'(bus.br_wdata), 64'd0);
    chk("rst_ready",    64'({bus.alu_ready, bus.mem_ready, bus.lnk_ready}), 64'd0);
    chk("rst_hit",      64'({bus.byp_a_hit, bus.byp_b_hit}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();

    // All three requesters valid for six cycles: ALU,MEM,LNK,ALU,MEM,LNK
    bus.alu_valid = 1; bus.alu_addr = 5'd1; bus.alu_data = 32'hA0;
    bus.mem_valid = 1; bus.mem_addr = 5'd2; bus.mem_data = 32'hB0;
    bus.lnk_valid = 1; bus.lnk_data = 32'hC0;
    for (int c = 0; c < 6; c++) exp_grant.push_back(c % 3);
    exp_wr.push_back(mk(5'd1,  32'hA0, 1'b0));
    exp_wr.push_back(mk(5'd2,  32'hB0, 1'b0));
    exp_wr.push_back(mk(5'd31, 32'hC0, 1'b1));
    exp_wr.push_back(mk(5'd1,  32'hA1, 1'b0));
    exp_wr.push_back(mk(5'd2,  32'hB1, 1'b0));
    exp_wr.push_back(mk(5'd31, 32'hC1, 1'b1));
    for (int c = 0; c < 6; c++) begin
      tick();
      case (c % 3)
        0: if (c < 3) bus.alu_data = 32'hA1; else bus.alu_valid = 0;
        1: if (c < 3) bus.mem_data = 32'hB1; else bus.mem_valid = 0;
        default: if (c < 3) bus.lnk_data = 32'hC1; else bus.lnk_valid = 0;
      endcase
    end
    repeat (2) tick();
    chk("rr_bank1",  64'(bank[1]),  64'hA1);
    chk("rr_bank2",  64'(bank[2]),  64'hB1);
    chk("rr_bank31", 64'(bank[31]), 64'hC1);

    // Single ALU write
    bus.alu_valid = 1; bus.alu_addr = 5'd5; bus.alu_data = 32'h1234;
    exp_grant.push_back(0); exp_wr.push_back(mk(5'd5, 32'h1234, 1'b0));
    @(negedge clk); chk("t1_alu_ready", 64'(bus.alu_ready), 64'd1);
    tick(); bus.alu_valid = 0;
    @(negedge clk); chk("t1_br_we", 64'(bus.br_we), 64'd1);
    tick();
    @(negedge clk); chk("t1_bank5", 64'(bank[5]), 64'h1234);
    tick();

    // MEM write to $0 is consumed but never staged
    bus.mem_valid = 1; bus.mem_addr = 5'd0; bus.mem_data = 32'hFFFF;
    exp_grant.push_back(1);
    @(negedge clk); chk("t3_mem_ready", 64'(bus.mem_ready), 64'd1);
    tick(); bus.mem_valid = 0;
    @(negedge clk); chk("t3_br_we", 64'(bus.br_we), 64'd0);
    tick();
    @(negedge clk); chk("t3_bank0", 64'(bank[0]), 64'd0);
    tick();

    // Bypass during the staging cycle
    bus.rd_addr_a = 5'd8; bus.rd_addr_b = 5'd0;
    bus.alu_valid = 1; bus.alu_addr = 5'd8; bus.alu_data = 32'd77;
    exp_grant.push_back(0); exp_wr.push_back(mk(5'd8, 32'd77, 1'b0));
    tick(); bus.alu_valid = 0;
    @(negedge clk);
    chk("t4_byp_a_hit", 64'(bus.byp_a_hit), 64'd1);
    chk("t4_byp_b_hit", 64'(bus.byp_b_hit), 64'd0);
    chk("t4_byp_data",  64'(bus.byp_data),  64'd77);
    tick();
    @(negedge clk);
    chk("t4_byp_a_after", 64'(bus.byp_a_hit), 64'd0);
    chk("t4_bank8",       64'(bank[8]),       64'd77);
    tick();

    // hold blocks acceptance for three cycles
    bus.hold = 1; bus.alu_valid = 1; bus.alu_addr = 5'd3; bus.alu_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_ready", 64'(bus.alu_ready), 64'd0);
      if (i == 1) chk("t5_hold_we", 64'(bus.br_we), 64'd0);
      tick();
    end
    bus.hold = 0;
    exp_grant.push_back(0); exp_wr.push_back(mk(5'd3, 32'h55, 1'b0));
    @(negedge clk); chk("t5_release_ready", 64'(bus.alu_ready), 64'd1);
    tick(); bus.alu_valid = 0;
    repeat (2) tick();

    // Reset while a MEM write is staged; pointer restarts at ALU
    bus.mem_valid = 1; bus.mem_addr = 5'd9; bus.mem_data = 32'h99;
    exp_grant.push_back(1);
    tick();
    bus.mem_addr = 5'd10; bus.mem_data = 32'hAA;
    bus.lnk_valid = 1; bus.lnk_data = 32'hCC;
    rst_n = 0;
    #1;
    chk("t6_async_we",   64'(bus.br_we),     64'd0);
    chk("t6_rst_ready",  64'({bus.mem_ready, bus.lnk_ready}), 64'd0);
    tick();
    exp_grant.push_back(1); exp_wr.push_back(mk(5'd10, 32'hAA, 1'b0));
    exp_grant.push_back(2); exp_wr.push_back(mk(5'd31, 32'hCC, 1'b1));
    rst_n = 1;
    @(negedge clk); chk("t6_mem_first", 64'(bus.mem_ready), 64'd1);
    tick(); bus.mem_valid = 0;
    tick(); bus.lnk_valid = 0;
    repeat (3) tick();
    chk("t6_bank9",  64'(bank[9]),  64'd0);
    chk("t6_bank10", 64'(bank[10]), 64'hAA);
    chk("t6_bank31", 64'(bank[31]), 64'hCC);

    chk("grant_queue_empty", 64'(exp_grant.size()), 64'd0);
    chk("write_queue_empty", 64'(exp_wr.size()),    64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
